tl_vc_router: RTL and testbench
===============================

// Module: tl_vc_router
// PURPOSE
// - Parametrised transaction-layer core: one ingress word stream is demuxed by class field into NUM_VC
//   virtual-channel FIFOs, each drained by its own consumer pop; watermark flow control, main FSM, sticky error.
// - Next-generation TL datapath: channel count, width and depth generic; adds runtime thresholds and error capture.
// PARAMETERS
// - DATA_W   6  word width; class field = data_in[DATA_W-1 -: VC_W]
// - NUM_VC   4  virtual channels (power of 2, >=2); VC_W = $clog2(NUM_VC)
// - DEPTH    4  words per VC FIFO (power of 2); CNT_W = $clog2(DEPTH)+1
// PORTS
// - clk        in   1              single clock, all logic on posedge
// - reset      in   1              synchronous, active-high
// - init       in   1              load thresholds (see FSM)
// - thr_low    in   CNT_W          almost-empty threshold
// - thr_high   in   CNT_W          almost-full threshold
// - push       in   1              ingress word valid
// - data_in    in   DATA_W         ingress word
// - pop        in   NUM_VC         per-VC read request
// - data_out   out  NUM_VC*DATA_W  per-VC registered read data, VC i at [i*DATA_W +: DATA_W]
// - valid_out  out  NUM_VC         per-VC data_out qualifier
// - almost_full out NUM_VC         count >= thr_high
// - almost_empty out NUM_VC        count <= thr_low
// - pause      out  1              OR of almost_full; upstream stops pushing
// - error_out  out  1              sticky overflow flag
// - state_out  out  3              FSM state
// - idle_out   out  1              state==IDLE
// BEHAVIOUR
// - Reset (sync, high): all FIFOs emptied, pointers/counts 0, data_out 0, valid_out 0, error_out 0,
//   state RESET, thresholds reg low=0, high=DEPTH; almost_empty all 1, almost_full 0, pause 0.
// - FSM: RESET -> INIT unconditionally next cycle. INIT: while init=1 latch thr_low/thr_high each cycle;
//   init=0 -> IDLE. IDLE: all FIFOs empty; push -> ACTIVE. ACTIVE: any FIFO non-empty or push; all empty
//   and no push -> IDLE. Any state: init=1 from IDLE/ACTIVE -> INIT (FIFO contents kept).
//   Overflow -> ERROR; ERROR exits only on reset. Encoding RESET=0 INIT=1 IDLE=2 ACTIVE=3 ERROR=4.
// - Push accepted in IDLE/ACTIVE only; ignored in RESET/INIT/ERROR. Target VC = class field.
// - Write: accepted push at edge n -> count visible n+1. Read: pop[i] at edge n with count>0 ->
//   data_out[i]/valid_out[i]=1 after edge n; valid_out[i]=0 cycle where pop[i]=0 or FIFO empty (data_out holds).
// - Simultaneous push+pop same VC: legal at any count incl. full (count unchanged, no error) and
//   empty (pop ignored, push lands; no bypass).
// - Overflow: push to full VC without same-cycle pop -> word dropped, error_out=1 next cycle, state ERROR.
//   In ERROR pops still served, pushes ignored.
// - Pointers wrap modulo DEPTH; counts 0..DEPTH. Watermarks combinational from counts and latched thresholds.
// CONFIGURATION
// - TL_PKT_COUNT_EN defined: adds output pkt_cnt (NUM_VC*8), per-VC 8-bit counters of accepted pushes,
//   wrap at 255->0, cleared by reset only. Undefined: port and counters absent; all else identical.
// STRUCTURE
// - Package tl_pkg: state localparams (ST_RESET..ST_ERROR), state width 3.
// - Sub-module tl_sync_fifo (DATA_W, DEPTH): push/pop/full/empty/count, registered read data;
//   instantiated NUM_VC times in a generate loop. Top holds FSM, demux, watermarks, error.
// TESTING
// - Reset, init=1 thr_low=1 thr_high=3 for 2 cycles, init=0 -> state 1 then 2, idle_out=1, pause=0.
// - Push 0x05,0x15,0x25,0x35 (classes 0..3) -> each count=1, state 3; pop=4'b1111 -> data_out
//   words 05,15,25,35, valid_out=4'b1111 next cycle; then state returns to 2.
// - Push 3 words class 2 -> almost_full[2]=1, pause=1; 4th -> full; pop[2]+push same cycle -> no error.
// - Push 5th word to full VC 1 without pop -> error_out=1, state 4; later push ignored, pops return 4 words.
// - Pop empty VC 0 -> valid_out[0]=0; reset mid-ACTIVE with 2 words queued -> all counts 0, state 0.
// - With TL_PKT_COUNT_EN: 257 pushes to VC 3 (with pops) -> pkt_cnt[31:24]=1.

Source files
------------

// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tl_pkg
// Purpose  : Shared definitions for the transaction-layer VC router: FSM
//            state encoding and state width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tl_pkg;

  localparam int unsigned ST_W = 3;

  // Encoding is architecturally visible on state_out, so values are fixed.
  typedef enum logic [ST_W-1:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } tl_state_e;

endpackage
`default_nettype wire

// File: rtl/tl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tl_sync_fifo
// Purpose  : Single-clock FIFO with registered read data. A pop on an empty
//            FIFO is ignored; a push on a full FIFO only lands when a pop is
//            served in the same cycle. No write-to-read bypass.
// Ports    : clk, reset     - clock, synchronous active-high reset
//            push_i, wdata_i - write request and data
//            pop_i           - read request
//            rdata_o         - read data, updated only on a served pop
//            rvalid_o        - high the cycle after a served pop
//            full_o, empty_o - occupancy flags
//            count_o         - occupancy 0..DEPTH
// Revision : 1.0 - initial release
// ============================================================================
module tl_sync_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [CW-1:0]     count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              do_push_w;
  logic              do_pop_w;

  assign empty_o  = (count_q == '0);
  assign full_o   = (count_q == CW'(DEPTH));
  assign count_o  = count_q;
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;

  // A served pop frees a slot this cycle, so a full FIFO can still accept.
  assign do_pop_w  = pop_i && !empty_o;
  assign do_push_w = push_i && (!full_o || do_pop_w);

  always_ff @(posedge clk) begin
    if (do_push_w && !reset) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      if (do_push_w) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop_w) begin
        rdata_q  <= mem_q[rd_ptr_q];
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      rvalid_q <= do_pop_w;
      if (do_push_w && !do_pop_w) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push_w && do_pop_w) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/tl_vc_router.sv
`default_nettype none
// ============================================================================
// Module   : tl_vc_router
// Purpose  : Transaction-layer core. One ingress word stream is demuxed by
//            its class field (top VC_W bits) into NUM_VC FIFOs, each drained
//            by its own pop. Watermark flow control against runtime
//            thresholds, a small control FSM and a sticky overflow flag.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            init, thr_low/high    - threshold load (while FSM in INIT)
//            push, data_in         - ingress word
//            pop                   - per-VC read request
//            data_out, valid_out   - per-VC registered read data/qualifier
//            almost_full/empty     - per-VC watermarks
//            pause                 - OR of almost_full
//            error_out             - sticky overflow flag
//            state_out, idle_out   - FSM state / state==IDLE
//            pkt_cnt               - per-VC 8-bit accepted-push counters
//                                    (only with TL_PKT_COUNT_EN defined)
// Config   : TL_PKT_COUNT_EN - enables pkt_cnt port and counters
// Revision : 1.0 - initial release
// ============================================================================
module tl_vc_router
  import tl_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int NUM_VC = 4,
  parameter int DEPTH  = 4,
  localparam int VC_W  = $clog2(NUM_VC),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic [CNT_W-1:0]         thr_low,
  input  logic [CNT_W-1:0]         thr_high,
  input  logic                     push,
  input  logic [DATA_W-1:0]        data_in,
  input  logic [NUM_VC-1:0]        pop,
  output logic [NUM_VC*DATA_W-1:0] data_out,
  output logic [NUM_VC-1:0]        valid_out,
  output logic [NUM_VC-1:0]        almost_full,
  output logic [NUM_VC-1:0]        almost_empty,
  output logic                     pause,
  output logic                     error_out,
  output logic [ST_W-1:0]          state_out,
  output logic                     idle_out
`ifdef TL_PKT_COUNT_EN
  ,
  output logic [NUM_VC*8-1:0]      pkt_cnt
`endif
);

  tl_state_e         state_q;
  tl_state_e         state_d;
  logic [CNT_W-1:0]  thr_low_q;
  logic [CNT_W-1:0]  thr_high_q;
  logic              error_q;

  logic              push_ok_w;
  logic [VC_W-1:0]   vc_sel_w;
  logic [NUM_VC-1:0] wr_req_w;
  logic [NUM_VC-1:0] ovf_w;
  logic [NUM_VC-1:0] full_w;
  logic [NUM_VC-1:0] empty_w;
  logic [CNT_W-1:0]  count_w [NUM_VC];
  logic              overflow_w;
  logic              all_empty_w;

  // Pushes only count while the FSM is in a traffic state.
  assign push_ok_w   = push && ((state_q == ST_IDLE) || (state_q == ST_ACTIVE));
  assign vc_sel_w    = data_in[DATA_W-1 -: VC_W];
  assign overflow_w  = |ovf_w;
  assign all_empty_w = &empty_w;

  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    logic sel_w;

    assign sel_w       = push_ok_w && (vc_sel_w == VC_W'(i));
    // Full + same-cycle pop is legal; full without pop drops the word.
    assign wr_req_w[i] = sel_w && (!full_w[i] || pop[i]);
    assign ovf_w[i]    = sel_w && full_w[i] && !pop[i];

    tl_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push_i   (wr_req_w[i]),
      .wdata_i  (data_in),
      .pop_i    (pop[i]),
      .rdata_o  (data_out[i*DATA_W +: DATA_W]),
      .rvalid_o (valid_out[i]),
      .full_o   (full_w[i]),
      .empty_o  (empty_w[i]),
      .count_o  (count_w[i])
    );

    assign almost_full[i]  = (count_w[i] >= thr_high_q);
    assign almost_empty[i] = (count_w[i] <= thr_low_q);

`ifdef TL_PKT_COUNT_EN
    logic [7:0] pkt_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        pkt_q <= '0;
      end else if (wr_req_w[i]) begin
        pkt_q <= pkt_q + 8'd1;
      end
    end

    assign pkt_cnt[i*8 +: 8] = pkt_q;
`endif
  end

  // Thresholds are only sampled while INIT is held with init asserted.
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_low_q  <= '0;
      thr_high_q <= CNT_W'(DEPTH);
    end else if ((state_q == ST_INIT) && init) begin
      thr_low_q  <= thr_low;
      thr_high_q <= thr_high;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (overflow_w) begin
      error_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_RESET: state_d = ST_INIT;
      ST_INIT: begin
        if (!init) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (overflow_w)                state_d = ST_ERROR;
        else if (init)                 state_d = ST_INIT;
        // Contents retained across INIT also move us back to ACTIVE.
        else if (push || !all_empty_w) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (overflow_w)                state_d = ST_ERROR;
        else if (init)                 state_d = ST_INIT;
        else if (all_empty_w && !push) state_d = ST_IDLE;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  assign pause     = |almost_full;
  assign error_out = error_q;
  assign state_out = state_q;
  assign idle_out  = (state_q == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_tl_vc_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_tl_vc_router
// Purpose  : Self-checking bench for tl_vc_router (default parameters).
//            A behavioural model (per-VC queues, FSM, thresholds) predicts
//            status outputs; expected read words go into a scoreboard queue
//            when a pop is driven and are compared when valid_out appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tl_vc_router;
  import tl_pkg::*;

  localparam int DATA_W = 6;
  localparam int NUM_VC = 4;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int VC_W   = 2;

  logic                     clk = 1'b0;
  logic                     reset = 1'b1;
  logic                     init = 1'b0;
  logic [CNT_W-1:0]         thr_low = '0;
  logic [CNT_W-1:0]         thr_high = '0;
  logic                     push = 1'b0;
  logic [DATA_W-1:0]        data_in = '0;
  logic [NUM_VC-1:0]        pop = '0;
  logic [NUM_VC*DATA_W-1:0] data_out;
  logic [NUM_VC-1:0]        valid_out;
  logic [NUM_VC-1:0]        almost_full;
  logic [NUM_VC-1:0]        almost_empty;
  logic                     pause;
  logic                     error_out;
  logic [2:0]               state_out;
  logic                     idle_out;
`ifdef TL_PKT_COUNT_EN
  logic [NUM_VC*8-1:0]      pkt_cnt;
`endif

  always #5 clk = ~clk;

  tl_vc_router #(
    .DATA_W (DATA_W),
    .NUM_VC (NUM_VC),
    .DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .init         (init),
    .thr_low      (thr_low),
    .thr_high     (thr_high),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .pause        (pause),
    .error_out    (error_out),
    .state_out    (state_out),
    .idle_out     (idle_out)
`ifdef TL_PKT_COUNT_EN
    ,
    .pkt_cnt      (pkt_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model + scoreboard ----------------
  typedef struct {
    int              vc;
    logic [DATA_W-1:0] d;
  } sb_t;

  sb_t               sb[$];
  logic [DATA_W-1:0] m_q [NUM_VC][$];
  int                m_state = 0;
  int                m_thr_lo = 0;
  int                m_thr_hi = DEPTH;
  int                m_err = 0;
  logic [NUM_VC-1:0] m_vld = '0;
  int                m_pkt [NUM_VC];

  task automatic step(input logic rs, input logic in_, input int tl, input int th,
                      input logic ps, input logic [DATA_W-1:0] d,
                      input logic [NUM_VC-1:0] pp);
    int   v;
    int   nxt;
    bit   acc;
    bit   ovf;
    bit   any_ne;
    logic [NUM_VC-1:0] e_af;
    logic [NUM_VC-1:0] e_ae;
    sb_t  e;

    reset    = rs;
    init     = in_;
    thr_low  = CNT_W'(tl);
    thr_high = CNT_W'(th);
    push     = ps;
    data_in  = d;
    pop      = pp;

    if (rs) begin
      for (int k = 0; k < NUM_VC; k++) begin
        m_q[k].delete();
        m_pkt[k] = 0;
      end
      m_state  = 0;
      m_thr_lo = 0;
      m_thr_hi = DEPTH;
      m_err    = 0;
      m_vld    = '0;
    end else begin
      v      = int'(d[DATA_W-1 -: VC_W]);
      acc    = ps && (m_state == 2 || m_state == 3);
      ovf    = acc && (m_q[v].size() == DEPTH) && !pp[v];
      any_ne = 1'b0;
      for (int k = 0; k < NUM_VC; k++) if (m_q[k].size() > 0) any_ne = 1'b1;
      case (m_state)
        0:       nxt = 1;
        1:       nxt = in_ ? 1 : 2;
        2:       nxt = ovf ? 4 : in_ ? 1 : (ps || any_ne) ? 3 : 2;
        3:       nxt = ovf ? 4 : in_ ? 1 : (!any_ne && !ps) ? 2 : 3;
        default: nxt = 4;
      endcase
      if (m_state == 1 && in_) begin
        m_thr_lo = tl;
        m_thr_hi = th;
      end
      if (ovf) m_err = 1;
      // Pops see pre-edge occupancy, so handle them before the push lands.
      for (int k = 0; k < NUM_VC; k++) begin
        m_vld[k] = 1'b0;
        if (pp[k] && m_q[k].size() > 0) begin
          e.vc = k;
          e.d  = m_q[k].pop_front();
          sb.push_back(e);
          m_vld[k] = 1'b1;
        end
      end
      if (acc && !ovf) begin
        m_q[v].push_back(d);
        m_pkt[v] = (m_pkt[v] + 1) % 256;
      end
      m_state = nxt;
    end

    @(posedge clk);
    #1;

    for (int k = 0; k < NUM_VC; k++) begin
      e_af[k] = (m_q[k].size() >= m_thr_hi);
      e_ae[k] = (m_q[k].size() <= m_thr_lo);
    end
    chk("m_state",        int'(state_out),    m_state);
    chk("m_error_out",    int'(error_out),    m_err);
    chk("m_valid_out",    int'(valid_out),    int'(m_vld));
    chk("m_almost_full",  int'(almost_full),  int'(e_af));
    chk("m_almost_empty", int'(almost_empty), int'(e_ae));
    chk("m_pause",        int'(pause),        int'(|e_af));
    chk("m_idle_out",     int'(idle_out),     (m_state == 2) ? 1 : 0);

    for (int k = 0; k < NUM_VC; k++) begin
      if (valid_out[k]) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_unexpected: got valid on vc %0d required no pending word", k);
        end else begin
          e = sb.pop_front();
          chk("sb_vc",   k, e.vc);
          chk("sb_data", int'(data_out[k*DATA_W +: DATA_W]), int'(e.d));
        end
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic              rs;
    logic              in_;
    int                tl;
    int                th;
    logic              ps;
    logic [DATA_W-1:0] d;
    logic [NUM_VC-1:0] pp;
    int                st;
    logic [NUM_VC-1:0] vld;
    logic [NUM_VC-1:0] af;
    logic [NUM_VC-1:0] ae;
    logic              err;
  } vec_t;

  vec_t vecs [21];

  initial begin
    for (int k = 0; k < NUM_VC; k++) m_pkt[k] = 0;

    //             rs in tl th ps  d      pp     st vld    af     ae     err
    vecs[0]  = '{1'b1,1'b0,0,0,1'b0,6'h00,4'h0, 0,4'h0,4'h0,4'hF,1'b0};
    vecs[1]  = '{1'b1,1'b0,0,0,1'b0,6'h00,4'h0, 0,4'h0,4'h0,4'hF,1'b0};
    vecs[2]  = '{1'b0,1'b1,1,3,1'b0,6'h00,4'h0, 1,4'h0,4'h0,4'hF,1'b0};
    vecs[3]  = '{1'b0,1'b1,1,3,1'b0,6'h00,4'h0, 1,4'h0,4'h0,4'hF,1'b0};
    vecs[4]  = '{1'b0,1'b0,0,0,1'b0,6'h00,4'h0, 2,4'h0,4'h0,4'hF,1'b0};
    vecs[5]  = '{1'b0,1'b0,0,0,1'b1,6'h05,4'h0, 3,4'h0,4'h0,4'hF,1'b0};
    vecs[6]  = '{1'b0,1'b0,0,0,1'b1,6'h15,4'h0, 3,4'h0,4'h0,4'hF,1'b0};
    vecs[7]  = '{1'b0,1'b0,0,0,1'b1,6'h25,4'h0, 3,4'h0,4'h0,4'hF,1'b0};
    vecs[8]  = '{1'b0,1'b0,0,0,1'b1,6'h35,4'h0, 3,4'h0,4'h0,4'hF,1'b0};
    vecs[9]  = '{1'b0,1'b0,0,0,1'b0,6'h00,4'hF, 3,4'hF,4'h0,4'hF,1'b0};
    vecs[10] = '{1'b0,1'b0,0,0,1'b0,6'h00,4'h0, 2,4'h0,4'h0,4'hF,1'b0};
    vecs[11] = '{1'b0,1'b0,0,0,1'b1,6'h21,4'h0, 3,4'h0,4'h0,4'hF,1'b0};
    vecs[12] = '{1'b0,1'b0,0,0,1'b1,6'h22,4'h0, 3,4'h0,4'h0,4'hB,1'b0};
    vecs[13] = '{1'b0,1'b0,0,0,1'b1,6'h23,4'h0, 3,4'h0,4'h4,4'hB,1'b0};
    vecs[14] = '{1'b0,1'b0,0,0,1'b1,6'h24,4'h0, 3,4'h0,4'h4,4'hB,1'b0};
    vecs[15] = '{1'b0,1'b0,0,0,1'b1,6'h2A,4'h4, 3,4'h4,4'h4,4'hB,1'b0};
    vecs[16] = '{1'b0,1'b0,0,0,1'b0,6'h00,4'h4, 3,4'h4,4'h4,4'hB,1'b0};
    vecs[17] = '{1'b0,1'b0,0,0,1'b0,6'h00,4'h4, 3,4'h4,4'h0,4'hB,1'b0};
    vecs[18] = '{1'b0,1'b0,0,0,1'b0,6'h00,4'h4, 3,4'h4,4'h0,4'hF,1'b0};
    vecs[19] = '{1'b0,1'b0,0,0,1'b0,6'h00,4'h4, 3,4'h4,4'h0,4'hF,1'b0};
    vecs[20] = '{1'b0,1'b0,0,0,1'b0,6'h00,4'h0, 2,4'h0,4'h0,4'hF,1'b0};

    for (int i = 0; i < 21; i++) begin
      step(vecs[i].rs, vecs[i].in_, vecs[i].tl, vecs[i].th,
           vecs[i].ps, vecs[i].d, vecs[i].pp);
      chk($sformatf("v%0d_state", i),        int'(state_out),    vecs[i].st);
      chk($sformatf("v%0d_valid_out", i),    int'(valid_out),    int'(vecs[i].vld));
      chk($sformatf("v%0d_almost_full", i),  int'(almost_full),  int'(vecs[i].af));
      chk($sformatf("v%0d_almost_empty", i), int'(almost_empty), int'(vecs[i].ae));
      chk($sformatf("v%0d_pause", i),        int'(pause),        int'(|vecs[i].af));
      chk($sformatf("v%0d_error_out", i),    int'(error_out),    int'(vecs[i].err));
    end

    // ---- overflow on VC 1: fill, then push without pop ----
    step(0, 0, 0, 0, 1, 6'h11, 4'h0);
    step(0, 0, 0, 0, 1, 6'h12, 4'h0);
    step(0, 0, 0, 0, 1, 6'h13, 4'h0);
    step(0, 0, 0, 0, 1, 6'h14, 4'h0);
    chk("ovf_pre_error", int'(error_out), 0);
    step(0, 0, 0, 0, 1, 6'h15, 4'h0);
    chk("ovf_error_out", int'(error_out), 1);
    chk("ovf_state",     int'(state_out), 4);
    step(0, 0, 0, 0, 1, 6'h16, 4'h0);   // ignored in ERROR
    chk("err_push_ignored_state", int'(state_out), 4);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 6'h00, 4'h2);
      chk($sformatf("err_pop%0d_valid", i), int'(valid_out[1]), 1);
    end
    step(0, 0, 0, 0, 0, 6'h00, 4'h2);
    chk("err_pop_drained_valid", int'(valid_out[1]), 0);
    chk("err_sticky", int'(error_out), 1);

    // ---- recover via reset, pop empty VC, reset mid-ACTIVE ----
    step(1, 0, 0, 0, 0, 6'h00, 4'h0);
    chk("rst_error_cleared", int'(error_out), 0);
    step(0, 0, 0, 0, 0, 6'h00, 4'h0);
    step(0, 0, 0, 0, 0, 6'h00, 4'h0);
    chk("reinit_idle", int'(idle_out), 1);
    step(0, 0, 0, 0, 0, 6'h00, 4'h1);
    chk("pop_empty_valid0", int'(valid_out[0]), 0);
    step(0, 0, 0, 0, 1, 6'h01, 4'h0);
    step(0, 0, 0, 0, 1, 6'h31, 4'h0);
    chk("two_queued_active", int'(state_out), 3);
    step(1, 0, 0, 0, 0, 6'h00, 4'h0);
    chk("midrst_state",        int'(state_out),    0);
    chk("midrst_almost_empty", int'(almost_empty), 15);
    chk("midrst_almost_full",  int'(almost_full),  0);
    chk("midrst_valid_out",    int'(valid_out),    0);

    // ---- sustained push+pop on VC 3 ----
    step(0, 0, 0, 0, 0, 6'h00, 4'h0);
    step(0, 0, 0, 0, 0, 6'h00, 4'h0);
    for (int i = 0; i < 257; i++) begin
      step(0, 0, 0, 0, 1, DATA_W'(6'h30 + (i % 16)), 4'h8);
    end
    step(0, 0, 0, 0, 0, 6'h00, 4'h8);
    step(0, 0, 0, 0, 0, 6'h00, 4'h0);
    chk("burst_back_idle", int'(state_out), 2);
`ifdef TL_PKT_COUNT_EN
    chk("pkt_cnt_vc3", int'(pkt_cnt[31:24]), 1);
    for (int k = 0; k < NUM_VC; k++) begin
      chk($sformatf("pkt_cnt_model_vc%0d", k), int'(pkt_cnt[k*8 +: 8]), m_pkt[k]);
    end
`endif
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
